// File: rtl/captura_ycbcr.sv
// YCbCr 4:2:2 camera front-end: turns the Y0 Cb Y1 Cr byte stream into one pixel
// per strobe with column/line coordinates and frame start/done markers.
module captura_ycbcr #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic           PCLK,
  input  logic           rst_n,
  input  logic           VSYNC,
  input  logic           HREF,
  input  logic [7:0]     D,
  output logic           e_pix,
  output logic [7:0]     Y,
  output logic [7:0]     Cb,
  output logic [7:0]     Cr,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start,
  output logic           frame_done,
  output logic           line_err
);

  // One extra bit on both counters so out-of-range columns/lines stay detectable.
  localparam int CW = X_W + 1;
  localparam int LW = Y_W + 1;
  localparam logic [CW-1:0] H_LIM = CW'(H_PIXELS);
  localparam logic [LW-1:0] V_LIM = LW'(V_LINES);

  typedef enum logic [1:0] {UNARMED, VBLANK, FRAME} state_t;

  state_t         state_q, state_d;
  logic           vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic           hr_q, hr_d, hr_prev_q, hr_prev_d;
  logic [7:0]     d_q, d_d;
  logic [1:0]     ph_q, ph_d;
  logic [7:0]     grp_y0_q, grp_y0_d, grp_cb_q, grp_cb_d;
  logic [7:0]     grp_y1_q, grp_y1_d, grp_cr_q, grp_cr_d;
  logic           pend_q, pend_d;
  logic [CW-1:0]  col_q, col_d, col_inc;
  logic [LW-1:0]  line_q, line_d;
  logic           e_pix_q, e_pix_d;
  logic [7:0]     luma_q, luma_d, cb_q, cb_d, cr_q, cr_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           frame_start_q, frame_start_d;
  logic           frame_done_q, frame_done_d;
  logic           line_err_q, line_err_d;
  logic           vs_rise, vs_fall, hr_fall, even_go;

  always_comb begin
    state_d       = state_q;
    vs_d          = VSYNC;
    hr_d          = HREF;
    d_d           = D;
    vs_prev_d     = vs_q;
    hr_prev_d     = hr_q;
    ph_d          = ph_q;
    grp_y0_d      = grp_y0_q;
    grp_cb_d      = grp_cb_q;
    grp_y1_d      = grp_y1_q;
    grp_cr_d      = grp_cr_q;
    pend_d        = 1'b0;
    col_d         = col_q;
    line_d        = line_q;
    e_pix_d       = 1'b0;
    luma_d        = luma_q;
    cb_d          = cb_q;
    cr_d          = cr_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    line_err_d    = line_err_q;

    vs_rise = vs_q & ~vs_prev_q;
    vs_fall = ~vs_q & vs_prev_q;
    hr_fall = ~hr_q & hr_prev_q;
    col_inc = (col_q == {CW{1'b1}}) ? col_q : col_q + 1'b1;
    even_go = (state_q == FRAME) && !vs_rise && hr_q && (ph_q == 2'd3);

    // Even pixel leaves as the Cr byte arrives; the odd one follows a cycle later.
    if (pend_q || even_go) begin
      col_d = col_inc;
      if (col_q >= H_LIM) begin
        line_err_d = 1'b1;
      end else if (line_q < V_LIM) begin
        e_pix_d = 1'b1;
        luma_d  = pend_q ? grp_y1_q : grp_y0_q;
        cb_d    = grp_cb_q;
        cr_d    = pend_q ? grp_cr_q : d_q;
        x_d     = col_q[X_W-1:0];
        y_d     = line_q[Y_W-1:0];
      end
    end

    case (state_q)
      UNARMED: begin
        if (vs_q) state_d = VBLANK;
      end
      VBLANK: begin
        if (vs_fall) begin
          state_d       = FRAME;
          frame_start_d = 1'b1;
          line_err_d    = 1'b0;
          line_d        = '0;
          col_d         = '0;
          ph_d          = 2'd0;
        end
      end
      FRAME: begin
        if (vs_rise) begin
          state_d      = VBLANK;
          frame_done_d = 1'b1;
          col_d        = '0;
          ph_d         = 2'd0;
          if (hr_q) line_err_d = 1'b1;
        end else if (hr_q) begin
          ph_d = ph_q + 2'd1;
          case (ph_q)
            2'd0:    grp_y0_d = d_q;
            2'd1:    grp_cb_d = d_q;
            2'd2:    grp_y1_d = d_q;
            default: begin
              grp_cr_d = d_q;
              pend_d   = 1'b1;
            end
          endcase
        end else if (hr_fall) begin
          // A pending odd pixel still belongs to this line, so count it here.
          if (ph_q != 2'd0) line_err_d = 1'b1;
          if ((col_q + CW'(pend_q)) != H_LIM) line_err_d = 1'b1;
          col_d  = '0;
          ph_d   = 2'd0;
          line_d = (line_q == {LW{1'b1}}) ? line_q : line_q + 1'b1;
        end
      end
      default: state_d = UNARMED;
    endcase
  end

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= UNARMED;
      vs_q          <= 1'b0;
      hr_q          <= 1'b0;
      d_q           <= '0;
      vs_prev_q     <= 1'b0;
      hr_prev_q     <= 1'b0;
      ph_q          <= 2'd0;
      grp_y0_q      <= '0;
      grp_cb_q      <= '0;
      grp_y1_q      <= '0;
      grp_cr_q      <= '0;
      pend_q        <= 1'b0;
      col_q         <= '0;
      line_q        <= '0;
      e_pix_q       <= 1'b0;
      luma_q        <= '0;
      cb_q          <= '0;
      cr_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_d;
      hr_q          <= hr_d;
      d_q           <= d_d;
      vs_prev_q     <= vs_prev_d;
      hr_prev_q     <= hr_prev_d;
      ph_q          <= ph_d;
      grp_y0_q      <= grp_y0_d;
      grp_cb_q      <= grp_cb_d;
      grp_y1_q      <= grp_y1_d;
      grp_cr_q      <= grp_cr_d;
      pend_q        <= pend_d;
      col_q         <= col_d;
      line_q        <= line_d;
      e_pix_q       <= e_pix_d;
      luma_q        <= luma_d;
      cb_q          <= cb_d;
      cr_q          <= cr_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      line_err_q    <= line_err_d;
    end
  end

  assign e_pix       = e_pix_q;
  assign Y           = luma_q;
  assign Cb          = cb_q;
  assign Cr          = cr_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign line_err    = line_err_q;

endmodule

// File: tb/tb_captura_ycbcr.sv
// Directed bench for captura_ycbcr with a 4-pixel, 3-line frame; a negedge
// monitor logs every strobe and frame marker for the checks.
module tb_captura_ycbcr;

  localparam int H_PIXELS = 4;
  localparam int V_LINES  = 3;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;

  logic           PCLK = 1'b0;
  logic           rst_n;
  logic           VSYNC;
  logic           HREF;
  logic [7:0]     D;
  logic           e_pix;
  logic [7:0]     Y, Cb, Cr;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           frame_start, frame_done, line_err;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  int fsCount = 0, fdCount = 0, fsCyc = 0, fdCyc = 0;
  int riseCyc = 0, fallCyc = 0;
  int qY[$], qCb[$], qCr[$], qX[$], qYl[$], qCyc[$];
  int crCyc[$];
  int lineBytes[12] = '{10, 128, 20, 200, 30, 60, 40, 90, 50, 70, 60, 80};
  int expY[4]  = '{10, 20, 30, 40};
  int expCb[4] = '{128, 128, 60, 60};
  int expCr[4] = '{200, 200, 90, 90};
  int savedCount;

  captura_ycbcr #(
    .H_PIXELS(H_PIXELS), .V_LINES(V_LINES), .X_W(X_W), .Y_W(Y_W)
  ) dut (
    .PCLK(PCLK), .rst_n(rst_n), .VSYNC(VSYNC), .HREF(HREF), .D(D),
    .e_pix(e_pix), .Y(Y), .Cb(Cb), .Cr(Cr), .x(x), .y(y),
    .frame_start(frame_start), .frame_done(frame_done), .line_err(line_err)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  // Outputs are logged mid-cycle, well away from the active edge.
  always @(negedge PCLK) begin
    if (e_pix) begin
      qY.push_back(int'(Y));
      qCb.push_back(int'(Cb));
      qCr.push_back(int'(Cr));
      qX.push_back(int'(x));
      qYl.push_back(int'(y));
      qCyc.push_back(cyc);
    end
    if (frame_start) begin
      fsCount = fsCount + 1;
      fsCyc   = cyc;
    end
    if (frame_done) begin
      fdCount = fdCount + 1;
      fdCyc   = cyc;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount = assertCount + 1;
    if (observed !== expected) begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge PCLK);
    #1;
    VSYNC = vs;
    HREF  = hr;
    D     = d;
  endtask

  task automatic sendLine(input int n);
    crCyc.delete();
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(lineBytes[i]));
      if (i % 4 == 3) crCyc.push_back(cyc);
    end
    repeat (4) applyStimulus(1'b0, 1'b0, 8'd0);
  endtask

  task automatic vsyncPulse();
    applyStimulus(1'b1, 1'b0, 8'd0);
    riseCyc = cyc;
    repeat (2) applyStimulus(1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'd0);
    fallCyc = cyc;
    repeat (3) applyStimulus(1'b0, 1'b0, 8'd0);
  endtask

  task automatic clearLog();
    qY.delete(); qCb.delete(); qCr.delete();
    qX.delete(); qYl.delete(); qCyc.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    VSYNC = 1'b0;
    HREF  = 1'b0;
    D     = 8'd0;
    repeat (2) @(posedge PCLK);
    #1;
    checkOutput("reset e_pix", int'(e_pix), 0);
    checkOutput("reset Y", int'(Y), 0);
    checkOutput("reset Cb", int'(Cb), 0);
    checkOutput("reset Cr", int'(Cr), 0);
    checkOutput("reset x", int'(x), 0);
    checkOutput("reset y", int'(y), 0);
    checkOutput("reset frame_start", int'(frame_start), 0);
    checkOutput("reset frame_done", int'(frame_done), 0);
    checkOutput("reset line_err", int'(line_err), 0);
    @(negedge PCLK);
    rst_n = 1'b1;

    // Activity before the first VSYNC must be ignored.
    sendLine(8);
    checkOutput("unarmed strobes", qY.size(), 0);
    checkOutput("unarmed frame_start", fsCount, 0);
    vsyncPulse();
    checkOutput("arm frame_done", fdCount, 0);
    checkOutput("first frame_start count", fsCount, 1);
    checkOutput("frame_start latency", fsCyc, fallCyc + 2);

    clearLog();
    sendLine(8);
    checkOutput("line0 strobe count", qY.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("line0 px%0d Y", i), qY[i], expY[i]);
      checkOutput($sformatf("line0 px%0d Cb", i), qCb[i], expCb[i]);
      checkOutput($sformatf("line0 px%0d Cr", i), qCr[i], expCr[i]);
      checkOutput($sformatf("line0 px%0d x", i), qX[i], i);
      checkOutput($sformatf("line0 px%0d y", i), qYl[i], 0);
      checkOutput($sformatf("line0 px%0d cycle", i), qCyc[i], crCyc[i / 2] + 2 + (i % 2));
    end
    checkOutput("line0 line_err", int'(line_err), 0);

    sendLine(8);
    sendLine(8);
    savedCount = qY.size();
    checkOutput("lines0-2 strobe count", savedCount, 12);
    sendLine(8);
    checkOutput("extra line strobes", qY.size() - savedCount, 0);
    checkOutput("last strobed y", qYl[qYl.size() - 1], V_LINES - 1);
    checkOutput("full frame line_err", int'(line_err), 0);
    vsyncPulse();
    checkOutput("frame_done count", fdCount, 1);
    checkOutput("frame_done latency", fdCyc, riseCyc + 2);
    checkOutput("second frame_start count", fsCount, 2);

    // Short line: the trailing Y0 Cb of a broken group is dropped.
    clearLog();
    sendLine(6);
    checkOutput("short strobe count", qY.size(), 2);
    checkOutput("short px0 Y", qY[0], 10);
    checkOutput("short px0 Cr", qCr[0], 200);
    checkOutput("short px1 Y", qY[1], 20);
    checkOutput("short px1 x", qX[1], 1);
    checkOutput("short line_err", int'(line_err), 1);
    vsyncPulse();
    checkOutput("line_err cleared", int'(line_err), 0);
    checkOutput("third frame_start count", fsCount, 3);

    clearLog();
    sendLine(12);
    checkOutput("long strobe count", qY.size(), 4);
    checkOutput("long last x", qX[qX.size() - 1], 3);
    checkOutput("long last Y", qY[qY.size() - 1], 40);
    checkOutput("long line_err", int'(line_err), 1);

    // Asynchronous reset in the middle of a group.
    clearLog();
    applyStimulus(1'b0, 1'b1, 8'd10);
    applyStimulus(1'b0, 1'b1, 8'd128);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset Y", int'(Y), 0);
    checkOutput("midreset Cb", int'(Cb), 0);
    checkOutput("midreset Cr", int'(Cr), 0);
    checkOutput("midreset x", int'(x), 0);
    checkOutput("midreset line_err", int'(line_err), 0);
    checkOutput("midreset e_pix", int'(e_pix), 0);
    @(negedge PCLK);
    rst_n = 1'b1;
    for (int i = 2; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'(lineBytes[i]));
    repeat (4) applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("post-reset strobes", qY.size(), 0);
    checkOutput("post-reset line_err", int'(line_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/captura_ycbcr.md
# captura_ycbcr

Camera front-end that deserializes the 8-bit YCbCr 4:2:2 byte stream (Y0 Cb Y1 Cr order) from the sensor's D/HREF/VSYNC bus into one pixel per strobe. It drives `e_pix`, `Y`, `Cb` and `Cr` straight into the green detector, plus pixel coordinates and frame markers for the downstream tracking logic. It runs entirely in the camera pixel-clock domain.

## Interface
- `H_PIXELS`, 640: valid pixels per line; pixels beyond this are dropped.
- `V_LINES`, 480: valid lines per frame; lines beyond this are dropped.
- `X_W`, 10: width of `x`.
- `Y_W`, 9: width of `y`.

Ports:
- `PCLK` in 1: pixel clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `VSYNC` in 1: high during vertical blanking.
- `HREF` in 1: high while line bytes are valid.
- `D` in 8: camera data byte.
- `e_pix` out 1: one-cycle strobe; `Y`/`Cb`/`Cr`/`x`/`y` are valid for one pixel.
- `Y` out 8: luma of the strobed pixel.
- `Cb` out 8: raw offset-binary chroma, 128 = zero.
- `Cr` out 8: raw offset-binary chroma, 128 = zero.
- `x` out X_W: column of the strobed pixel, 0-based.
- `y` out Y_W: line of the strobed pixel, 0-based.
- `frame_start` out 1: one-cycle pulse on the VSYNC falling edge.
- `frame_done` out 1: one-cycle pulse on the VSYNC rising edge ending a captured frame.
- `line_err` out 1: sticky flag; cleared by `frame_start`.

## Operation
- VSYNC and HREF are registered once. Edges are detected against the previous registered value. D is sampled in the same cycle as the registered HREF; bytes are aligned to registered HREF=1.

States:
- `UNARMED`: entered from reset. Nothing is captured.
- UNARMED -> `VBLANK` when VSYNC is sampled high.
- VBLANK -> `FRAME` on the VSYNC falling edge: pulse `frame_start`, clear `line_err`, set the line counter to 0.
- FRAME -> VBLANK on the VSYNC rising edge: pulse `frame_done`.

Byte phase counter:
- 2-bit counter `ph`, active in FRAME while HREF=1.
- ph0 latches Y0, ph1 latches Cb, ph2 latches Y1, ph3 latches Cr. The counter wraps 3 -> 0.
- On ph3, the group is complete. Emit pixel (Y0, Cb, Cr) at column 2n, then pixel (Y1, Cb, Cr) at column 2n+1, where n is the group index within the line.

Column counter:
- Increments per emitted pixel.
- A pixel with column >= H_PIXELS gets no strobe, and `line_err` is set.

End of line (HREF falling edge):
- If ph != 0, the partial group is discarded and `line_err` is set.
- If the columns emitted != H_PIXELS, `line_err` is set.
- The column counter and ph are reset to 0.
- The line counter increments. Lines with index >= V_LINES produce no strobes.

Outputs:
- Y/Cb/Cr/x/y are registered and hold their last value between strobes.
- HREF or VSYNC activity in UNARMED produces no output.

## Timing
- Reset values: `e_pix`, `frame_start`, `frame_done` and `line_err` = 0; `Y`, `Cb`, `Cr`, `x`, `y` = 0; state UNARMED; ph = 0.
- Cr byte on D in cycle t (registered at edge t+1):
  - `e_pix`=1 in cycle t+2 with the even pixel.
  - `e_pix`=1 in cycle t+3 with the odd pixel.
- Minimum pixel-strobe spacing is 1 cycle inside a group and 3 cycles between groups. The detector needs no back-pressure; there is none.
- A pending odd pixel is still emitted if HREF falls in the cycle after ph3.
- `frame_start` and `frame_done` are asserted 2 cycles after the VSYNC edge on the pin.
- Reset asserted mid-frame clears everything asynchronously. After release the block returns to UNARMED, so a partial frame is never captured.
- A VSYNC rising edge while HREF=1 ends the frame. The partial group is discarded and `line_err` is set.

## Test plan
- **Reset then mid-frame start:** HREF bursts occur before any VSYNC -> `e_pix` never asserts. After a VSYNC high-low sequence, `frame_start` pulses once.
- **One line, H_PIXELS=4, bytes 10,128,20,200,30,60,40,90:**
  - Strobes give (Y,Cb,Cr,x) = (10,128,200,0), (20,128,200,1), (30,60,90,2), (40,60,90,3), all with y=0.
  - Strobe cycles are t+2 and t+3 after each Cr byte.
  - `line_err` stays 0.
- **Short line, 6 bytes:** 2 pixels are emitted, the last 2 bytes are discarded, and `line_err`=1. `line_err` clears on the next `frame_start`.
- **Long line, 12 bytes with H_PIXELS=4:** exactly 4 strobes, `line_err`=1.
- **Frame of V_LINES+1 lines:** the last line produces no strobe. `frame_done` pulses once on VSYNC rise, and the last strobed y = V_LINES-1.
- **rst_n pulsed between bytes of a group:** all outputs read 0 immediately. The following bytes in the same frame produce no `e_pix`.
